pcm_rom_cache: RTL and testbench

Line buffer between the jt6295 ADPCM ROM port and the shared SDRAM read channel. It turns the sample engine's single-byte fetches (18-bit address, `rom_ok` handshake) into 8-byte line fills, issued as 4-beat 16-bit bursts. Repeated and sequential nibble reads are then served from registers rather than SDRAM. It sits directly downstream of the jt6295 `rom_addr`/`rom_data`/`rom_ok` pins and replaces the ad-hoc `pcm_rom_read`/`pcm_data_rdy` glue in the top level.

---
 rtl/pcm_rom_cache.sv | 240 ++++++++++++++++++++++++
 tb/tb_pcm_rom_cache.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_rom_cache.sv
// pcm_rom_cache: byte-wide jt6295 ROM port served from an 8-byte line filled by 4-beat SDRAM bursts.
// Optional feature macro PCM_PREFETCH_EN adds a second line that is prefetched with the next sequential line.
module pcm_rom_cache #(
   parameter logic [24:0] SDRAM_BASE = 25'hE8000,
   parameter int          ADDR_W     = 18
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] rom_addr,
   output logic [7:0]        rom_data,
   output logic              rom_ok,
   output logic              sd_req,
   output logic [24:0]       sd_addr,
   input  logic              sd_ack,
   input  logic              sd_valid,
   input  logic [15:0]       sd_data
);

   localparam int TAG_W = ADDR_W - 3;
   localparam logic [TAG_W-1:0] TAG_ONE = {{(TAG_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FILL = 2'd2
   } state_t;

   function automatic logic [7:0] line_byte(input logic [63:0] line, input logic [2:0] sel);
      line_byte = line[{sel, 3'b000} +: 8];
   endfunction

   function automatic logic [24:0] line_addr(input logic [TAG_W-1:0] tag);
      line_addr = SDRAM_BASE + 25'({tag, 3'b000});
   endfunction

   state_t           state_r;
   state_t           state_s;
   logic [63:0]      line0_r;
   logic [TAG_W-1:0] tag0_r;
   logic             v0_r;
   logic [47:0]      fill_buf_r;
   logic [TAG_W-1:0] fill_tag_r;
   logic [1:0]       cnt_r;
   logic             sd_req_r;
   logic [24:0]      sd_addr_r;
   logic             ok_q_r;
   logic [7:0]       rom_data_r;
   logic [ADDR_W-1:0] addr_q_r;

   logic [TAG_W-1:0] req_tag_s;
   logic             hit0_s;
   logic             start_s;
   logic [TAG_W-1:0] start_tag_s;
   logic             last_beat_s;
   logic             ok_next_s;

`ifdef PCM_PREFETCH_EN
   logic [63:0]      line1_r;
   logic [TAG_W-1:0] tag1_r;
   logic             v1_r;
   logic             fill_to1_r;
   logic             hit1_s;
   logic             swap_s;
   logic             pf_need_s;
   logic             start_pf_s;
   logic [TAG_W-1:0] next_tag_s;
`endif

   assign req_tag_s = rom_addr[ADDR_W-1:3];
   assign hit0_s    = v0_r && (tag0_r == req_tag_s);

`ifdef PCM_PREFETCH_EN
   assign hit1_s     = v1_r && (tag1_r == req_tag_s);
   assign next_tag_s = tag0_r + TAG_ONE;
   assign pf_need_s  = v0_r && (!v1_r || (tag1_r != next_tag_s));
   // Line 0 is untouched while a prefetch fills line 1, so hits keep being served.
   assign ok_next_s  = hit0_s && ((state_r == IDLE) || fill_to1_r);
`else
   assign ok_next_s  = hit0_s && (state_r == IDLE);
`endif

   // Next-state and request-launch decode
   always_comb begin
      state_s     = state_r;
      start_s     = 1'b0;
      start_tag_s = req_tag_s;
      last_beat_s = 1'b0;
`ifdef PCM_PREFETCH_EN
      swap_s      = 1'b0;
      start_pf_s  = 1'b0;
`endif
      case (state_r)
         IDLE: begin
`ifdef PCM_PREFETCH_EN
            if (!hit0_s && hit1_s) begin
               swap_s  = 1'b1;
               state_s = IDLE;
            end else if (!hit0_s) begin
               start_s = 1'b1;
               state_s = REQ;
            end else if (pf_need_s) begin
               start_s     = 1'b1;
               start_pf_s  = 1'b1;
               start_tag_s = next_tag_s;
               state_s     = REQ;
            end else begin
               state_s = IDLE;
            end
`else
            if (!hit0_s) begin
               start_s = 1'b1;
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
`endif
         end
         REQ: begin
            if (sd_ack) begin
               state_s = FILL;
            end else begin
               state_s = REQ;
            end
         end
         FILL: begin
            if (sd_valid && (cnt_r == 2'd3)) begin
               last_beat_s = 1'b1;
               state_s     = IDLE;
            end else begin
               state_s = FILL;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, SDRAM request and beat assembly registers
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         sd_req_r   <= 1'b0;
         sd_addr_r  <= 25'd0;
         fill_tag_r <= '0;
         cnt_r      <= 2'd0;
         fill_buf_r <= 48'd0;
`ifdef PCM_PREFETCH_EN
         fill_to1_r <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         if (start_s) begin
            fill_tag_r <= start_tag_s;
            sd_addr_r  <= line_addr(start_tag_s);
            sd_req_r   <= 1'b1;
`ifdef PCM_PREFETCH_EN
            fill_to1_r <= start_pf_s;
`endif
         end else if ((state_r == REQ) && sd_ack) begin
            sd_req_r <= 1'b0;
            cnt_r    <= 2'd0;
         end else if ((state_r == FILL) && sd_valid) begin
            cnt_r <= cnt_r + 2'd1;
            case (cnt_r)
               2'd0:    fill_buf_r[15:0]  <= sd_data;
               2'd1:    fill_buf_r[31:16] <= sd_data;
               2'd2:    fill_buf_r[47:32] <= sd_data;
               default: fill_buf_r        <= fill_buf_r;
            endcase
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Line storage: commit on the last beat (beat 3 goes straight in), swap on a line-1 hit
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         line0_r <= 64'd0;
         tag0_r  <= '0;
         v0_r    <= 1'b0;
`ifdef PCM_PREFETCH_EN
         line1_r <= 64'd0;
         tag1_r  <= '0;
         v1_r    <= 1'b0;
`endif
      end else begin
`ifdef PCM_PREFETCH_EN
         if (last_beat_s && fill_to1_r) begin
            line1_r <= {sd_data, fill_buf_r};
            tag1_r  <= fill_tag_r;
            v1_r    <= 1'b1;
         end else if (last_beat_s) begin
            line0_r <= {sd_data, fill_buf_r};
            tag0_r  <= fill_tag_r;
            v0_r    <= 1'b1;
         end else if (swap_s) begin
            line0_r <= line1_r;
            tag0_r  <= tag1_r;
            v0_r    <= 1'b1;
            v1_r    <= 1'b0;
         end else begin
            v0_r <= v0_r;
         end
`else
         if (last_beat_s) begin
            line0_r <= {sd_data, fill_buf_r};
            tag0_r  <= fill_tag_r;
            v0_r    <= 1'b1;
         end else begin
            v0_r <= v0_r;
         end
`endif
      end
   end

   // Registered read port; addr_q lets rom_ok drop in the same cycle the address moves
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         ok_q_r     <= 1'b0;
         rom_data_r <= 8'h00;
         addr_q_r   <= '0;
      end else begin
         addr_q_r <= rom_addr;
         ok_q_r   <= ok_next_s;
         if (ok_next_s) begin
            rom_data_r <= line_byte(line0_r, rom_addr[2:0]);
         end else begin
            rom_data_r <= rom_data_r;
         end
      end
   end

   assign rom_ok   = ok_q_r & (rom_addr == addr_q_r);
   assign rom_data = rom_data_r;
   assign sd_req   = sd_req_r;
   assign sd_addr  = sd_addr_r;

endmodule

// File: tb/tb_pcm_rom_cache.sv
// Self-checking bench for pcm_rom_cache: directed sequences plus a table of hit vectors.
module tb_pcm_rom_cache;

   typedef struct packed {
      logic [17:0] addr;
      logic [7:0]  data;
   } vec_t;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [17:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_ok;
   logic        sd_req;
   logic [24:0] sd_addr;
   logic        sd_ack;
   logic        sd_valid;
   logic [15:0] sd_data;

   int   n_chk   = 0;
   int   n_pass  = 0;
   int   req_cnt = 0;
   logic req_d   = 1'b0;
   vec_t vecs [10];

   pcm_rom_cache dut (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .rom_ok   (rom_ok),
      .sd_req   (sd_req),
      .sd_addr  (sd_addr),
      .sd_ack   (sd_ack),
      .sd_valid (sd_valid),
      .sd_data  (sd_data)
   );

   always #5 clk_sys = ~clk_sys;

   // count distinct SDRAM requests (rising edges of sd_req)
   always @(negedge clk_sys) begin
      if (sd_req === 1'b1 && req_d !== 1'b1) req_cnt <= req_cnt + 1;
      req_d <= sd_req;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_req(input string nm, input logic [24:0] exp_addr, output bit got);
      int n = 0;
      while (sd_req !== 1'b1 && n < 40) begin
         step();
         settle();
         n++;
      end
      got = (sd_req === 1'b1);
      chk({nm, "_req"}, 32'(sd_req), 32'd1);
      if (got) chk({nm, "_addr"}, 32'(sd_addr), 32'(exp_addr));
   endtask

   task automatic ack_req(input string nm, input logic [24:0] exp_addr);
      step();
      settle();
      chk({nm, "_hold"}, 32'(sd_req), 32'd1);
      chk({nm, "_stable"}, 32'(sd_addr), 32'(exp_addr));
      step();
      sd_ack = 1'b1;
      settle();
   endtask

   // full burst: ack two cycles after sd_req, four back-to-back beats; returns settled in cycle B+1
   task automatic serve(input string nm, input logic [24:0] exp_addr, input logic [3:0][15:0] b,
                        input logic ok_during, input int sw_beat, input logic [17:0] sw_addr);
      bit got;
      wait_req(nm, exp_addr, got);
      if (got) begin
         ack_req(nm, exp_addr);
         for (int i = 0; i < 4; i++) begin
            step();
            sd_ack   = 1'b0;
            sd_valid = 1'b1;
            sd_data  = b[i];
            if (i == sw_beat) rom_addr = sw_addr;
            settle();
            if (i == 0) chk({nm, "_req_drop"}, 32'(sd_req), 32'd0);
            chk($sformatf("%s_ok_beat%0d", nm, i), 32'(rom_ok), 32'(ok_during));
         end
         step();
         sd_valid = 1'b0;
         settle();
      end
   endtask

   task automatic expect_hit(input string nm, input logic [7:0] data);
      step();
      settle();
      chk({nm, "_ok"}, 32'(rom_ok), 32'd1);
      chk({nm, "_data"}, 32'(rom_data), 32'(data));
   endtask

   initial begin
      int   rc;
      bit   got;

      vecs[0] = '{addr: 18'h00010, data: 8'h00};
      vecs[1] = '{addr: 18'h00011, data: 8'h11};
      vecs[2] = '{addr: 18'h00012, data: 8'h22};
      vecs[3] = '{addr: 18'h00013, data: 8'h33};
      vecs[4] = '{addr: 18'h00014, data: 8'h44};
      vecs[5] = '{addr: 18'h00015, data: 8'h55};
      vecs[6] = '{addr: 18'h00016, data: 8'h66};
      vecs[7] = '{addr: 18'h00017, data: 8'h77};
      vecs[8] = '{addr: 18'h00013, data: 8'h33};
      vecs[9] = '{addr: 18'h00011, data: 8'h11};

      reset_n  = 1'b0;
      rom_addr = 18'h00013;
      sd_ack   = 1'b0;
      sd_valid = 1'b0;
      sd_data  = 16'h0000;

      // reset held 3 cycles with sd_valid toggling
      for (int i = 0; i < 3; i++) begin
         step();
         sd_valid = ~sd_valid;
         sd_data  = 16'hDEAD;
         settle();
         chk("rst_ok", 32'(rom_ok), 32'd0);
         chk("rst_req", 32'(sd_req), 32'd0);
         chk("rst_data", 32'(rom_data), 32'd0);
      end
      step();
      reset_n  = 1'b1;
      sd_valid = 1'b0;
      settle();
      chk("post_rst_ok", 32'(rom_ok), 32'd0);
      chk("post_rst_req", 32'(sd_req), 32'd0);

      // cold miss at 0x13: no line is valid after reset, so a request must follow
      serve("cold", 25'hE8010, {16'h7766, 16'h5544, 16'h3322, 16'h1100}, 1'b0, -1, 18'h0);
      chk("cold_b1_ok", 32'(rom_ok), 32'd0);
      expect_hit("cold_b2", 8'h33);
      chk("cold_req_cnt", 32'(req_cnt), 32'd1);

`ifdef PCM_PREFETCH_EN
      // next line 0x18 is prefetched while 0x13 keeps hitting
      serve("pf18", 25'hE8018, {16'hE7E6, 16'hE5E4, 16'hE3E2, 16'hE1E0}, 1'b1, -1, 18'h0);
      chk("pf18_after_ok", 32'(rom_ok), 32'd1);

      step();
      rom_addr = 18'h3FFF8;
      settle();
      chk("wrap_chg_ok", 32'(rom_ok), 32'd0);
      serve("wrap", 25'h127FF8, {16'hB7B6, 16'hB5B4, 16'hB3B2, 16'hB1B0}, 1'b0, -1, 18'h0);
      step();
      settle();
      chk("wrap_b2_ok", 32'(rom_ok), 32'd1);
      chk("wrap_b2_data", 32'(rom_data), 32'hB0);
      chk("wrap_pf_req", 32'(sd_req), 32'd1);
      chk("wrap_pf_addr", 32'(sd_addr), 32'h0E8000);
      serve("pf0", 25'hE8000, {16'hD7D6, 16'hD5D4, 16'hD3D2, 16'hD1D0}, 1'b1, -1, 18'h0);

      // line-1 hit swaps in: rom_ok 2 cycles after the change, no demand request
      step();
      rom_addr = 18'h00000;
      settle();
      rc = req_cnt;
      chk("swap_c0_ok", 32'(rom_ok), 32'd0);
      step();
      settle();
      chk("swap_c1_ok", 32'(rom_ok), 32'd0);
      chk("swap_c1_req", 32'(sd_req), 32'd0);
      expect_hit("swap_c2", 8'hD0);
      chk("swap_req_cnt", 32'(req_cnt), 32'(rc));
`else
      // table: sequential and repeated bytes in the line, 1-cycle hit latency
      rc = req_cnt;
      for (int i = 0; i < 10; i++) begin
         step();
         rom_addr = vecs[i].addr;
         settle();
         chk($sformatf("tbl%0d_chg_ok", i), 32'(rom_ok), 32'd0);
         step();
         settle();
         chk($sformatf("tbl%0d_ok", i), 32'(rom_ok), 32'd1);
         chk($sformatf("tbl%0d_data", i), 32'(rom_data), 32'(vecs[i].data));
         chk($sformatf("tbl%0d_req", i), 32'(sd_req), 32'd0);
      end
      chk("tbl_req_cnt", 32'(req_cnt), 32'(rc));

      // address change mid-fill: first fill completes, then the new line is requested
      step();
      rom_addr = 18'h00020;
      settle();
      rc = req_cnt;
      serve("mid1", 25'hE8020, {16'h2726, 16'h2524, 16'h2322, 16'h2120}, 1'b0, 2, 18'h00100);
      chk("mid1_b1_ok", 32'(rom_ok), 32'd0);
      chk("mid1_b1_req", 32'(sd_req), 32'd0);
      serve("mid2", 25'hE8100, {16'hA7A6, 16'hA5A4, 16'hA3A2, 16'hA1A0}, 1'b0, -1, 18'h0);
      chk("mid2_b1_ok", 32'(rom_ok), 32'd0);
      expect_hit("mid2_b2", 8'hA0);
      chk("mid_req_cnt", 32'(req_cnt), 32'(rc + 2));

      // reset after beat 2, then a stray beat 3: nothing commits, fresh request follows
      step();
      rom_addr = 18'h00040;
      settle();
      wait_req("rmid", 25'hE8040, got);
      ack_req("rmid", 25'hE8040);
      for (int i = 0; i < 3; i++) begin
         step();
         sd_ack   = 1'b0;
         sd_valid = 1'b1;
         sd_data  = 16'h4140 + 16'(i * 16'h0202);
         settle();
      end
      step();
      reset_n  = 1'b0;
      sd_valid = 1'b0;
      settle();
      step();
      reset_n  = 1'b1;
      sd_valid = 1'b1;
      sd_data  = 16'h4746;
      settle();
      chk("rmid_ok", 32'(rom_ok), 32'd0);
      chk("rmid_data", 32'(rom_data), 32'd0);
      chk("rmid_req_cleared", 32'(sd_req), 32'd0);
      step();
      sd_valid = 1'b0;
      settle();
      chk("rmid_nocommit_ok", 32'(rom_ok), 32'd0);
      serve("rfresh", 25'hE8040, {16'hC7C6, 16'hC5C4, 16'hC3C2, 16'hC1C0}, 1'b0, -1, 18'h0);
      expect_hit("rfresh_b2", 8'hC0);

      // top line then wrap to 0: no prefetch, demand request only when rom_addr reaches 0
      step();
      rom_addr = 18'h3FFF8;
      settle();
      serve("wrap", 25'h127FF8, {16'hB7B6, 16'hB5B4, 16'hB3B2, 16'hB1B0}, 1'b0, -1, 18'h0);
      expect_hit("wrap_b2", 8'hB0);
      rc = req_cnt;
      for (int i = 0; i < 6; i++) begin
         step();
         settle();
         chk($sformatf("wrap_idle%0d_req", i), 32'(sd_req), 32'd0);
      end
      chk("wrap_no_pf_cnt", 32'(req_cnt), 32'(rc));
      step();
      rom_addr = 18'h00000;
      settle();
      chk("zero_chg_ok", 32'(rom_ok), 32'd0);
      serve("zero", 25'hE8000, {16'hD7D6, 16'hD5D4, 16'hD3D2, 16'hD1D0}, 1'b0, -1, 18'h0);
      expect_hit("zero_b2", 8'hD0);
      chk("zero_req_cnt", 32'(req_cnt), 32'(rc + 1));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
